// File: rtl/gnn_out_serializer.sv
// Serializes one captured frame of GNN output features onto a valid/ready stream.
// Optional macro GNN_OUT_DROPCNT_EN adds an 8-bit saturating dropped-strobe counter port.
module gnn_out_serializer #(
  parameter int NUM_NODES     = 4,
  parameter int OUTS_PER_NODE = 2,
  parameter int DATA_W        = 21
) (
  input  logic                                           clk,
  input  logic                                           rst_n,
  input  logic                                           out_ready,
  input  logic [NUM_NODES*OUTS_PER_NODE*DATA_W-1:0]      out_data,
  output logic                                           m_valid,
  input  logic                                           m_ready,
  output logic [DATA_W-1:0]                              m_data,
  output logic [(NUM_NODES > 1 ? $clog2(NUM_NODES) : 1)-1:0]         m_node,
  output logic [(OUTS_PER_NODE > 1 ? $clog2(OUTS_PER_NODE) : 1)-1:0] m_idx,
  output logic                                           m_last,
  output logic                                           busy,
`ifdef GNN_OUT_DROPCNT_EN
  output logic [7:0]                                     drop_cnt,
`endif
  output logic                                           overrun
);

  localparam int NW     = NUM_NODES * OUTS_PER_NODE;
  localparam int PTR_W  = (NW > 1) ? $clog2(NW) : 1;
  localparam int NODE_W = (NUM_NODES > 1) ? $clog2(NUM_NODES) : 1;
  localparam int IDX_W  = (OUTS_PER_NODE > 1) ? $clog2(OUTS_PER_NODE) : 1;

  typedef enum logic {IDLE, SEND} state_t;

  state_t                   state_q, state_d;
  logic [PTR_W-1:0]         ptr_q, ptr_d;
  logic                     overrun_q, overrun_d;
  logic [NW*DATA_W-1:0]     buf_q;
  logic                     capture;
  logic                     drop;
  logic                     last_word;
  logic signed [DATA_W-1:0] word_sel;

  assign last_word = (ptr_q == PTR_W'(NW - 1));

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    overrun_d = overrun_q;
    capture   = 1'b0;
    drop      = 1'b0;
    case (state_q)
      IDLE: begin
        if (out_ready) begin
          capture = 1'b1;
          ptr_d   = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (m_ready && last_word) begin
          // A strobe coinciding with the final handshake starts the next frame with no bubble
          ptr_d = '0;
          if (out_ready) capture = 1'b1;
          else           state_d = IDLE;
        end else begin
          if (m_ready) ptr_d = ptr_q + 1'b1;
          if (out_ready) begin
            drop      = 1'b1;
            overrun_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      overrun_q <= overrun_d;
    end
  end

  // Frame buffer carries data only; its contents after reset are irrelevant
  always_ff @(posedge clk) begin
    if (capture) buf_q <= out_data;
  end

`ifdef GNN_OUT_DROPCNT_EN
  logic [7:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop && (drop_cnt_q != 8'hFF)) drop_cnt_d = drop_cnt_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) drop_cnt_q <= 8'd0;
    else        drop_cnt_q <= drop_cnt_d;
  end

  assign drop_cnt = drop_cnt_q;
`endif

  always_comb begin
    word_sel = buf_q[int'(ptr_q)*DATA_W +: DATA_W];
    m_valid  = (state_q == SEND);
    busy     = (state_q == SEND);
    m_data   = '0;
    m_node   = '0;
    m_idx    = '0;
    m_last   = 1'b0;
    if (state_q == SEND) begin
      m_data = word_sel;
      m_node = NODE_W'(int'(ptr_q) / OUTS_PER_NODE);
      m_idx  = IDX_W'(int'(ptr_q) % OUTS_PER_NODE);
      m_last = last_word;
    end
  end

  assign overrun = overrun_q;

endmodule
